// File: rtl/mod_rate_sched.sv
// Programmable symbol-rate scheduler: run-time divisor, symbol tick, 50%-duty divided
// clock and a per-frame symbol counter with start/stop/finish sequencing.
module mod_rate_sched #(
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned LEN_W       = 8,
   parameter int unsigned DEFAULT_DIV = 12500
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cfg_valid_i,
   input  logic [DIV_W-1:0] cfg_div_i,
   input  logic [LEN_W-1:0] cfg_len_i,
   output logic             cfg_ready_o,
   input  logic             start_i,
   input  logic             stop_i,
   output logic             tick_o,
   output logic             clk_div_o,
   output logic [LEN_W-1:0] sym_idx_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_e;

   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

   state_e             state_q;
   logic [DIV_W-1:0]   div_q;
   logic [LEN_W-1:0]   len_q;
   logic [DIV_W-1:0]   cnt_q;
   logic [LEN_W-1:0]   sym_idx_q;
   logic               tick_q;
   logic               clk_div_q;
   logic               done_q;
   logic               busy_q;
   logic               cfg_ready_q;

   logic               last_cnt;
   logic [LEN_W-1:0]   sym_next;
   logic [DIV_W-1:0]   cfg_div_clamped;

   assign last_cnt        = (cnt_q == (div_q - DIV_W'(1)));
   assign sym_next        = sym_idx_q + LEN_W'(1);
   assign cfg_div_clamped = (cfg_div_i < DIV_MIN) ? DIV_MIN : cfg_div_i;

   // Frame sequencer; tick and done are single-cycle pulses cleared by default.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         div_q       <= DIV_RST;
         len_q       <= '0;
         cnt_q       <= '0;
         sym_idx_q   <= '0;
         tick_q      <= 1'b0;
         clk_div_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         tick_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cfg_valid_i) begin
                  div_q <= cfg_div_clamped;
                  len_q <= cfg_len_i;
               end
               if (start_i) begin
                  cnt_q       <= '0;
                  sym_idx_q   <= '0;
                  clk_div_q   <= 1'b0;
                  state_q     <= S_RUN;
                  busy_q      <= 1'b1;
                  cfg_ready_q <= 1'b0;
               end
            end
            S_RUN: begin
               // Stop beats a coincident tick: the symbol is dropped and sym_idx holds.
               if (stop_i) begin
                  cnt_q       <= '0;
                  clk_div_q   <= 1'b0;
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  cfg_ready_q <= 1'b1;
               end else if (last_cnt) begin
                  cnt_q     <= '0;
                  tick_q    <= 1'b1;
                  clk_div_q <= ~clk_div_q;
                  sym_idx_q <= sym_next;
                  if ((len_q != '0) && (sym_next == len_q)) begin
                     state_q <= S_FINISH;
                  end
               end else begin
                  cnt_q <= cnt_q + DIV_W'(1);
               end
            end
            S_FINISH: begin
               state_q     <= S_IDLE;
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               cfg_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               cfg_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cfg_ready_o = cfg_ready_q;
   assign tick_o      = tick_q;
   assign clk_div_o   = clk_div_q;
   assign sym_idx_o   = sym_idx_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_mod_rate_sched.sv
// Self-checking bench for mod_rate_sched: directed scenarios plus random traffic,
// every cycle compared against a frame-level model built from elapsed-cycle arithmetic.
module tb_mod_rate_sched;

   localparam int unsigned DIV_W       = 16;
   localparam int unsigned LEN_W       = 8;
   localparam int unsigned DEFAULT_DIV = 12500;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             cfg_valid_i;
   logic [DIV_W-1:0] cfg_div_i;
   logic [LEN_W-1:0] cfg_len_i;
   logic             cfg_ready_o;
   logic             start_i;
   logic             stop_i;
   logic             tick_o;
   logic             clk_div_o;
   logic [LEN_W-1:0] sym_idx_o;
   logic             busy_o;
   logic             done_o;

   int vectors     = 0;
   int miscompares = 0;

   // Model: frame described by elapsed cycles since start; tick n occurs at k == n*div.
   bit m_run, m_fin, m_tick, m_done, m_cdiv;
   int m_div, m_len, m_idx, m_k;

   mod_rate_sched #(.DIV_W(DIV_W), .LEN_W(LEN_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cfg_valid_i(cfg_valid_i),
      .cfg_div_i  (cfg_div_i),
      .cfg_len_i  (cfg_len_i),
      .cfg_ready_o(cfg_ready_o),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .tick_o     (tick_o),
      .clk_div_o  (clk_div_o),
      .sym_idx_o  (sym_idx_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #10 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int n;
      m_tick = 1'b0;
      m_done = 1'b0;
      if (rst_i) begin
         m_run = 1'b0; m_fin = 1'b0; m_div = DEFAULT_DIV; m_len = 0;
         m_idx = 0; m_cdiv = 1'b0; m_k = 0;
      end else if (m_fin) begin
         m_fin  = 1'b0;
         m_done = 1'b1;
      end else if (m_run) begin
         m_k++;
         if (stop_i) begin
            m_run  = 1'b0;
            m_cdiv = 1'b0;
         end else if (m_k % m_div == 0) begin
            n      = m_k / m_div;
            m_tick = 1'b1;
            m_idx  = n % 256;
            m_cdiv = n[0];
            if (m_len != 0 && n == m_len) begin
               m_run = 1'b0;
               m_fin = 1'b1;
            end
         end
      end else begin
         if (cfg_valid_i) begin
            m_div = (int'(cfg_div_i) < 2) ? 2 : int'(cfg_div_i);
            m_len = int'(cfg_len_i);
         end
         if (start_i) begin
            m_run = 1'b1; m_k = 0; m_idx = 0; m_cdiv = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      chk("tick",      32'(tick_o),      32'(m_tick));
      chk("clk_div",   32'(clk_div_o),   32'(m_cdiv));
      chk("sym_idx",   32'(sym_idx_o),   32'(m_idx));
      chk("busy",      32'(busy_o),      32'(m_run | m_fin));
      chk("done",      32'(done_o),      32'(m_done));
      chk("cfg_ready", 32'(cfg_ready_o), 32'(!(m_run | m_fin)));
   endtask

   task automatic cyc();
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      check_all();
   endtask

   task automatic quiet();
      rst_i = 1'b0; cfg_valid_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
   endtask

   task automatic cfg_start(input int div, input int len);
      cfg_valid_i = 1'b1; cfg_div_i = DIV_W'(div); cfg_len_i = LEN_W'(len); start_i = 1'b1;
      cyc();
      quiet();
   endtask

   initial begin
      int ticks, done_at, dones, first_tick;
      int rises[$];
      int tick_at[$];
      logic prev;

      quiet();
      cfg_div_i = '0; cfg_len_i = '0;

      // 1: reset, default divisor, continuous frame
      rst_i = 1'b1; cyc(); cyc();
      chk("rst_ready", 32'(cfg_ready_o), 32'd1);
      chk("rst_busy",  32'(busy_o),      32'd0);
      quiet();
      start_i = 1'b1; cyc(); quiet();
      ticks = 0; prev = 1'b0;
      for (int i = 1; i <= 37510; i++) begin
         cyc();
         if (tick_o === 1'b1) ticks++;
         if (clk_div_o === 1'b1 && prev === 1'b0) rises.push_back(i);
         prev = clk_div_o;
      end
      chk("t1_ticks", 32'(ticks), 32'd3);
      chk("t1_rises", 32'(rises.size()), 32'd2);
      if (rises.size() >= 2) chk("t1_period", 32'(rises[1] - rises[0]), 32'd25000);
      chk("t1_first_rise", 32'(rises.size() > 0 ? rises[0] : 0), 32'd12500);
      stop_i = 1'b1; cyc(); quiet(); cyc();

      // 2: cfg and start on the same edge
      cfg_start(4, 3);
      done_at = 0;
      for (int i = 1; i <= 14; i++) begin
         cyc();
         if (tick_o === 1'b1) tick_at.push_back(i);
         if (done_o === 1'b1) done_at = i;
         if (i == 13) chk("t2_busy13", 32'(busy_o), 32'd0);
      end
      chk("t2_nticks", 32'(tick_at.size()), 32'd3);
      for (int j = 0; j < tick_at.size() && j < 3; j++) chk("t2_tick_at", 32'(tick_at[j]), 32'(4 * (j + 1)));
      chk("t2_done_at", 32'(done_at), 32'd13);
      chk("t2_sym_idx", 32'(sym_idx_o), 32'd3);

      // 3: divisor 0 clamps to 2
      cfg_start(0, 2);
      tick_at.delete(); done_at = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         if (tick_o === 1'b1) tick_at.push_back(i);
         if (done_o === 1'b1) done_at = i;
      end
      chk("t3_nticks", 32'(tick_at.size()), 32'd2);
      if (tick_at.size() == 2) chk("t3_spacing", 32'(tick_at[1] - tick_at[0]), 32'd2);
      chk("t3_done_at", 32'(done_at), 32'd5);

      // 4: stop coincident with the third tick
      cfg_start(5, 0);
      for (int i = 1; i <= 14; i++) cyc();
      stop_i = 1'b1; cyc(); quiet();
      chk("t4_tick",    32'(tick_o),    32'd0);
      chk("t4_sym_idx", 32'(sym_idx_o), 32'd2);
      chk("t4_busy",    32'(busy_o),    32'd0);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (done_o === 1'b1) dones++;
      end
      chk("t4_no_done", 32'(dones), 32'd0);
      chk("t4_hold",    32'(sym_idx_o), 32'd2);

      // 5: cfg during RUN ignored, accepted again after done
      cfg_start(3, 2);
      cfg_valid_i = 1'b1; cfg_div_i = 16'd9; cfg_len_i = 8'd7;
      cyc(); cyc(); quiet();
      for (int i = 0; i < 8; i++) cyc();
      chk("t5_sym_idx", 32'(sym_idx_o), 32'd2);
      chk("t5_ready",   32'(cfg_ready_o), 32'd1);
      cfg_start(9, 1);
      first_tick = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         if (tick_o === 1'b1 && first_tick == 0) first_tick = i;
      end
      chk("t5_new_period", 32'(first_tick), 32'd9);

      // 6: reset in the middle of a frame
      cfg_start(4, 10);
      for (int i = 1; i <= 21; i++) cyc();
      chk("t6_pre_idx", 32'(sym_idx_o), 32'd5);
      rst_i = 1'b1; cyc(); quiet();
      chk("t6_busy",    32'(busy_o),      32'd0);
      chk("t6_sym_idx", 32'(sym_idx_o),   32'd0);
      chk("t6_clk_div", 32'(clk_div_o),   32'd0);
      chk("t6_ready",   32'(cfg_ready_o), 32'd1);
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (done_o === 1'b1) dones++;
      end
      chk("t6_no_done", 32'(dones), 32'd0);

      // sym_idx wrap with continuous frame
      cfg_start(2, 0);
      for (int i = 0; i < 530; i++) cyc();
      stop_i = 1'b1; cyc(); quiet();

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         rst_i       = ($urandom_range(0, 299) == 0);
         cfg_valid_i = ($urandom_range(0, 3) == 0);
         cfg_div_i   = DIV_W'($urandom_range(0, 7));
         cfg_len_i   = LEN_W'($urandom_range(0, 5));
         start_i     = ($urandom_range(0, 7) == 0);
         stop_i      = ($urandom_range(0, 39) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
